// File: rtl/stage4_rice_pack.sv
// stage4_rice_pack: zigzag + Rice coding of signed residuals with escape codes, packed MSB-first into 32-bit words.
module stage4_rice_pack #(
    parameter int QMAX = 15,
    parameter int KMAX = 14
) (
    input  logic        iClock,
    input  logic        iReset,
    input  logic        iEnable,
    input  logic [15:0] iResidual,
    input  logic        iValid,
    input  logic [3:0]  iRiceParam,
    input  logic        iParamLoad,
    input  logic        iFlush,
    output logic [31:0] oData,
    output logic        oValid,
    output logic        oDone,
    output logic [31:0] oBitCount
);
    typedef enum logic [1:0] {RUN, DRAIN, PAD} state_t;
    state_t      state_q, state_d;
    logic [1:0]  dcnt_q, dcnt_d;
    logic [3:0]  k_q, k_d, k_in;
    logic        a_vld_q, a_vld_d;
    logic [15:0] a_u_q, a_u_d;
    logic [3:0]  a_k_q, a_k_d;
    logic        b_vld_q, b_vld_d;
    logic [31:0] b_code_q, b_code_d;
    logic [5:0]  b_len_q, b_len_d;
    logic [63:0] bits_q, bits_d, bits_n;
    logic [5:0]  fill_q, fill_d, fill_n;
    logic [31:0] data_q, data_d, cnt_q, cnt_d;
    logic        valid_q, valid_d, done_q, done_d;
    logic [15:0] q, low;
    logic        esc;

    always_comb begin
        k_in = iParamLoad ? ((iRiceParam > 4'(KMAX)) ? 4'(KMAX) : iRiceParam) : k_q;
        k_d = k_in;
        a_vld_d = iValid && state_q == RUN;
        a_u_d = {iResidual[14:0], 1'b0} ^ {16{iResidual[15]}};
        a_k_d = k_in;
        q = a_u_q >> a_k_q;
        low = a_u_q & ~(16'hFFFF << a_k_q);
        esc = q > 16'(QMAX);
        b_vld_d = a_vld_q;
        // codes are held right-aligned; len says how many low bits are meaningful
        b_code_d = esc ? {16'b0, a_u_q} : (32'd1 << a_k_q) | {16'b0, low};
        b_len_d = esc ? 6'(QMAX + 17) : 6'(q) + 6'(a_k_q) + 6'd1;
        bits_n = bits_q | (b_vld_q ? ({b_code_q << (6'd32 - b_len_q), 32'b0} >> fill_q) : 64'b0);
        fill_n = fill_q + (b_vld_q ? b_len_q : 6'd0);
        valid_d = fill_n[5];
        data_d = fill_n[5] ? bits_n[63:32] : data_q;
        bits_d = fill_n[5] ? {bits_n[31:0], 32'b0} : bits_n;
        fill_d = {1'b0, fill_n[4:0]};
        cnt_d = cnt_q + (b_vld_q ? 32'(b_len_q) : 32'd0);
        done_d = 1'b0;
        state_d = state_q;
        dcnt_d = dcnt_q;
        case (state_q)
            RUN: begin
                state_d = iFlush ? DRAIN : RUN;
                dcnt_d = 2'd0;
            end
            DRAIN: begin
                dcnt_d = dcnt_q + 2'd1;
                state_d = (dcnt_q == 2'd2) ? PAD : DRAIN;
            end
            PAD: begin
                data_d = bits_q[63:32];
                valid_d = fill_q != 6'd0;
                done_d = 1'b1;
                bits_d = 64'b0;
                fill_d = 6'd0;
                cnt_d = 32'd0;
                state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            state_q  <= RUN;
            dcnt_q   <= 2'd0;
            k_q      <= 4'd0;
            a_vld_q  <= 1'b0;
            a_u_q    <= 16'd0;
            a_k_q    <= 4'd0;
            b_vld_q  <= 1'b0;
            b_code_q <= 32'd0;
            b_len_q  <= 6'd0;
            bits_q   <= 64'd0;
            fill_q   <= 6'd0;
            data_q   <= 32'd0;
            cnt_q    <= 32'd0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
        end else if (iEnable) begin
            state_q  <= state_d;
            dcnt_q   <= dcnt_d;
            k_q      <= k_d;
            a_vld_q  <= a_vld_d;
            a_u_q    <= a_u_d;
            a_k_q    <= a_k_d;
            b_vld_q  <= b_vld_d;
            b_code_q <= b_code_d;
            b_len_q  <= b_len_d;
            bits_q   <= bits_d;
            fill_q   <= fill_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
        end
    end

    // strobes stay latched while disabled and reappear on resume
    assign oData     = data_q;
    assign oValid    = valid_q & iEnable;
    assign oDone     = done_q & iEnable;
    assign oBitCount = cnt_q;
endmodule

// File: tb/tb_stage4_rice_pack.sv
// tb_stage4_rice_pack: scoreboard bench for the Rice packer; directed vectors plus a bit-level reference model.
module tb_stage4_rice_pack;
    logic        iClock = 1'b0;
    logic        iReset, iEnable, iValid, iParamLoad, iFlush;
    logic [15:0] iResidual;
    logic [3:0]  iRiceParam;
    logic [31:0] oData, oBitCount;
    logic        oValid, oDone;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    typedef struct {
        logic        v;
        logic        d;
        logic [31:0] data;
        int          at;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;
    bit   mq[$];
    int   mk;

    stage4_rice_pack dut (
        .iClock(iClock), .iReset(iReset), .iEnable(iEnable), .iResidual(iResidual),
        .iValid(iValid), .iRiceParam(iRiceParam), .iParamLoad(iParamLoad), .iFlush(iFlush),
        .oData(oData), .oValid(oValid), .oDone(oDone), .oBitCount(oBitCount)
    );

    always #5 iClock = ~iClock;
    always @(posedge iClock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic expect_ev(input logic v, input logic d, input logic [31:0] data, input int at);
        exp_t e;
        e.v = v; e.d = d; e.data = data; e.at = at;
        sb.push_back(e);
    endtask

    always @(negedge iClock) begin
        if (!iReset && (oValid || oDone)) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output valid=%0b done=%0b data=%h want none", oValid, oDone, oData);
            end else begin
                mon_e = sb.pop_front();
                chk("valid", 32'(oValid), 32'(mon_e.v));
                chk("done", 32'(oDone), 32'(mon_e.d));
                if (mon_e.v) chk("data", oData, mon_e.data);
                if (mon_e.at >= 0) chk("latency", 32'(cyc), 32'(mon_e.at));
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge iClock);
        #1;
    endtask

    task automatic drive(input logic v, input int r, input logic ld, input int k, input logic fl);
        iValid = v; iResidual = 16'(r); iParamLoad = ld; iRiceParam = 4'(k); iFlush = fl;
        step();
        iValid = 1'b0; iParamLoad = 1'b0; iFlush = 1'b0;
    endtask

    task automatic wait_empty(input string nm);
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            step();
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s timeout pending=%0d want 0", nm, sb.size());
            sb.delete();
        end
    endtask

    task automatic model_push(input int r, input bit ld, input int k);
        int u, q;
        logic [31:0] w;
        if (ld) mk = (k > 14) ? 14 : k;
        u = (r >= 0) ? 2 * r : -2 * r - 1;
        q = u >> mk;
        if (q <= 15) begin
            repeat (q) mq.push_back(1'b0);
            mq.push_back(1'b1);
            for (int i = mk - 1; i >= 0; i--) mq.push_back(u[i]);
        end else begin
            repeat (16) mq.push_back(1'b0);
            for (int i = 15; i >= 0; i--) mq.push_back(u[i]);
        end
        while (mq.size() >= 32) begin
            w = 0;
            for (int i = 0; i < 32; i++) w = {w[30:0], mq.pop_front()};
            expect_ev(1'b1, 1'b0, w, -1);
        end
    endtask

    task automatic model_flush();
        logic [31:0] w;
        if (mq.size() > 0) begin
            w = 0;
            for (int i = 0; i < 32; i++) w = {w[30:0], (mq.size() > 0) ? mq.pop_front() : 1'b0};
            expect_ev(1'b1, 1'b1, w, -1);
        end else begin
            expect_ev(1'b0, 1'b1, 32'd0, -1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int c;
        int r6[16] = '{5, -7, 0, 1, -1, 300, -3000, 12, -12, 7, 32767, -32768, 2, -5, 100, 9};
        int k6[16] = '{1, 2, 0, 3, 0, 1, 4, 2, 2, 9, 14, 13, 1, 6, 15, 2};
        bit ld6[16] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 1, 1, 0, 1, 1};
        iReset = 1'b1; iEnable = 1'b1; iValid = 1'b0; iParamLoad = 1'b0; iFlush = 1'b0;
        iResidual = 16'd0; iRiceParam = 4'd0;
        step(2);
        chk("reset_data", oData, 32'd0);
        chk("reset_valid", 32'(oValid), 32'd0);
        chk("reset_done", 32'(oDone), 32'd0);
        chk("reset_bitcount", oBitCount, 32'd0);
        iReset = 1'b0;
        step();

        // k=2: codes 0110 and 111 padded into one word; drop/ignore during drain, k=0 still latched
        expect_ev(1'b1, 1'b1, 32'h6E00_0000, -1);
        drive(1'b1, 3, 1'b1, 2, 1'b0);
        drive(1'b1, -2, 1'b0, 0, 1'b1);
        drive(1'b1, 5, 1'b1, 0, 1'b1);
        step();
        chk("bitcount_before_pad", oBitCount, 32'd7);
        wait_empty("flush_pad");
        chk("bitcount_after_pad", oBitCount, 32'd0);

        // 32 zeros at k=0 fill exactly one word, 3 cycles after the last residual
        c = cyc;
        expect_ev(1'b1, 1'b0, 32'hFFFF_FFFF, c + 34);
        for (int i = 0; i < 32; i++) drive(1'b1, 0, 1'b0, 0, 1'b0);
        wait_empty("all_ones");
        chk("bitcount_32", oBitCount, 32'd32);

        // escape code is exactly one word
        expect_ev(1'b1, 1'b0, 32'h0000_00C8, cyc + 3);
        drive(1'b1, 100, 1'b0, 0, 1'b0);
        wait_empty("escape");
        chk("bitcount_64", oBitCount, 32'd64);
        expect_ev(1'b0, 1'b1, 32'd0, -1);
        drive(1'b0, 0, 1'b0, 0, 1'b1);
        wait_empty("empty_flush");
        chk("bitcount_cleared", oBitCount, 32'd0);

        // k=15 clamps to 14
        drive(1'b1, -32768, 1'b1, 15, 1'b0);
        step(2);
        chk("bitcount_18", oBitCount, 32'd18);
        expect_ev(1'b1, 1'b1, 32'h1FFF_C000, -1);
        drive(1'b0, 0, 1'b0, 0, 1'b1);
        wait_empty("clamp_pad");

        // reset with 20 bits buffered discards them
        drive(1'b1, 0, 1'b1, 0, 1'b0);
        for (int i = 0; i < 19; i++) drive(1'b1, 0, 1'b0, 0, 1'b0);
        step(3);
        chk("bitcount_20", oBitCount, 32'd20);
        iReset = 1'b1;
        step();
        iReset = 1'b0;
        step();
        chk("bitcount_after_reset", oBitCount, 32'd0);
        expect_ev(1'b0, 1'b1, 32'd0, -1);
        drive(1'b0, 0, 1'b0, 0, 1'b1);
        wait_empty("reset_flush");
        chk("bitcount_reset_flush", oBitCount, 32'd0);

        // mixed stream with a bubble and a 5-cycle enable gap fed with junk
        mq.delete();
        mk = 0;
        for (int i = 0; i < 16; i++) begin
            if (i == 4) drive(1'b0, 0, 1'b0, 0, 1'b0);
            if (i == 9) begin
                iEnable = 1'b0;
                repeat (5) drive(1'b1, 1234, 1'b1, 7, 1'b1);
                iEnable = 1'b1;
            end
            drive(1'b1, r6[i], ld6[i], k6[i], 1'b0);
            model_push(r6[i], ld6[i], k6[i]);
        end
        model_flush();
        drive(1'b0, 0, 1'b0, 0, 1'b1);
        wait_empty("model_stream");
        chk("bitcount_final", oBitCount, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
